// File: rtl/l1_refill_pkg.sv
// Shared geometry, request payload and FSM encoding for the L1 refill responder.
package l1_refill_pkg;

    function automatic int unsigned calc_beats(input int unsigned line_bytes, input int unsigned data_w);
        return line_bytes / (data_w / 8);
    endfunction

    function automatic int unsigned calc_offset_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned calc_beat_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int unsigned calc_line_addr_w(input int unsigned addr_w, input int unsigned line_bytes);
        return addr_w - calc_offset_w(line_bytes);
    endfunction

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned LINE_BYTES      = 64;
    localparam int unsigned NUM_MSHR        = 4;
    localparam int unsigned DEF_MEM_LATENCY = 8;

    localparam int unsigned ID_W        = $clog2(NUM_MSHR);
    localparam int unsigned BEATS       = calc_beats(LINE_BYTES, DATA_W);
    localparam int unsigned BEAT_W      = calc_beat_w(BEATS);
    localparam int unsigned OFFSET_W    = calc_offset_w(LINE_BYTES);
    localparam int unsigned LINE_ADDR_W = calc_line_addr_w(ADDR_W, LINE_BYTES);
    localparam int unsigned WB          = $clog2(DATA_W / 8);

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] line_addr;
        logic [ID_W-1:0]        id;
    } refill_req_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        RESP,
        SEND
    } refill_state_e;

endpackage

// File: rtl/l1_refill_responder_req_fifo.sv
// Request queue: circular FIFO of line requests with full/empty flags and occupancy.
module l1_refill_req_fifo
    import l1_refill_pkg::*;
#(
    parameter int unsigned DEPTH = NUM_MSHR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  refill_req_t                  push_data,
    input  logic                         pop,
    output refill_req_t                  pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    refill_req_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/l1_refill_responder.sv
// Serves queued L1 line fills: waits the memory latency, reads each word, returns tagged beats.
module l1_refill_responder
    import l1_refill_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [LINE_ADDR_W-1:0] req_line_addr,
    input  logic [ID_W-1:0]        req_id,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic                   refill_valid,
    input  logic                   refill_ready,
    output logic [ID_W-1:0]        refill_id,
    output logic [BEAT_W-1:0]      refill_beat,
    output logic [DATA_W-1:0]      refill_data,
    output logic                   refill_last,
    output logic                   refill_done,
    output logic [ID_W-1:0]        refill_done_id,
    output logic                   busy,
    output logic                   err_dup_id
);

    localparam int unsigned       LAT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned       CNT_W     = $clog2(NUM_MSHR + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    refill_state_e          state_q;
    refill_state_e          state_d;
    logic [LINE_ADDR_W-1:0] cur_line_q;
    logic [ID_W-1:0]        cur_id_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [LAT_W-1:0]       lat_q;
    logic [DATA_W-1:0]      data_q;
    logic [NUM_MSHR-1:0]    pending_q;
    logic [NUM_MSHR-1:0]    pending_d;
    logic                   err_q;

    refill_req_t            req_in;
    refill_req_t            fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_pop;
    logic                   req_acc;
    logic                   dup_hit;

    assign req_in.line_addr = req_line_addr;
    assign req_in.id        = req_id;
    assign req_ready        = !fifo_full;
    assign req_acc          = req_valid && !fifo_full;

    l1_refill_req_fifo #(
        .DEPTH (NUM_MSHR)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_acc),
        .push_data (req_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = WAIT;
            WAIT:    if (lat_q == '0) state_d = READ;
            READ:    state_d = RESP;
            RESP:    state_d = SEND;
            SEND:    if (refill_ready) state_d = (beat_q == LAST_BEAT) ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop     = 1'b0;
        mem_rd_en    = 1'b0;
        refill_valid = 1'b0;
        case (state_q)
            IDLE:    fifo_pop     = !fifo_empty;
            READ:    mem_rd_en    = 1'b1;
            SEND:    refill_valid = 1'b1;
            default: ;
        endcase
    end

    assign mem_rd_addr    = {cur_line_q, beat_q, {WB{1'b0}}};
    assign refill_id      = cur_id_q;
    assign refill_beat    = beat_q;
    assign refill_data    = data_q;
    assign refill_last    = refill_valid && (beat_q == LAST_BEAT);
    assign refill_done    = refill_valid && refill_ready && refill_last;
    assign refill_done_id = cur_id_q;
    assign busy           = (state_q != IDLE) || (fifo_count != '0);
    assign err_dup_id     = err_q;

    // Line context, latency/beat counters and the captured read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_line_q <= '0;
            cur_id_q   <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            data_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (!fifo_empty) begin
                    cur_line_q <= fifo_head.line_addr;
                    cur_id_q   <= fifo_head.id;
                    beat_q     <= '0;
                    lat_q      <= LAT_W'(MEM_LATENCY - 1);
                end
                WAIT: if (lat_q != '0) lat_q <= lat_q - LAT_W'(1);
                RESP: data_q <= mem_rd_data;
                SEND: if (refill_ready && (beat_q != LAST_BEAT)) beat_q <= beat_q + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    // A new accept for an id wins over that id's completion in the same cycle.
    always_comb begin
        pending_d = pending_q;
        if (refill_done) pending_d[cur_id_q] = 1'b0;
        if (req_acc)     pending_d[req_id]   = 1'b1;
    end

    assign dup_hit = req_acc && pending_q[req_id] && !(refill_done && (cur_id_q == req_id));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_q | dup_hit;
        end
    end

endmodule

// File: tb/tb_l1_refill_responder.sv
// Directed scoreboard bench for l1_refill_responder with a word=address backing memory.
module tb_l1_refill_responder;
    import l1_refill_pkg::*;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [BEAT_W-1:0] beat;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic                   clk;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [LINE_ADDR_W-1:0] req_line_addr;
    logic [ID_W-1:0]        req_id;
    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [DATA_W-1:0]      mem_rd_data;
    logic                   refill_valid;
    logic                   refill_ready;
    logic [ID_W-1:0]        refill_id;
    logic [BEAT_W-1:0]      refill_beat;
    logic [DATA_W-1:0]      refill_data;
    logic                   refill_last;
    logic                   refill_done;
    logic [ID_W-1:0]        refill_done_id;
    logic                   busy;
    logic                   err_dup_id;

    int    total = 0;
    int    bad   = 0;
    int    edges = 0;
    int    acc_edge = 0;
    beat_t sb[$];

    logic                            stall_q = 1'b0;
    logic [ID_W+BEAT_W+DATA_W-1:0]   prev_fields = '0;

    l1_refill_responder dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_line_addr  (req_line_addr),
        .req_id         (req_id),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .refill_valid   (refill_valid),
        .refill_ready   (refill_ready),
        .refill_id      (refill_id),
        .refill_beat    (refill_beat),
        .refill_data    (refill_data),
        .refill_last    (refill_last),
        .refill_done    (refill_done),
        .refill_done_id (refill_done_id),
        .busy           (busy),
        .err_dup_id     (err_dup_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Backing memory returns the word address itself, one cycle after the strobe.
    initial mem_rd_data = '0;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_rd_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push_line(input logic [LINE_ADDR_W-1:0] line, input logic [ID_W-1:0] id);
        beat_t e;
        logic [BEAT_W-1:0] b;
        for (int k = 0; k < int'(BEATS); k++) begin
            b      = BEAT_W'(k);
            e.id   = id;
            e.beat = b;
            e.data = DATA_W'({line, b, 2'b00});
            e.last = (k == int'(BEATS) - 1);
            sb.push_back(e);
        end
    endtask

    // Called at step time; returns at step time one cycle after the accepting edge.
    task automatic push_req(input logic [LINE_ADDR_W-1:0] line, input logic [ID_W-1:0] id);
        req_valid     = 1'b1;
        req_line_addr = line;
        req_id        = id;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) break;
            step();
        end
        chk("push_ready", 64'(req_ready), 1);
        acc_edge = edges + 1;
        sb_push_line(line, id);
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},    64'(req_ready), 1);
        chk({tag, "_mem_rd_en"},    64'(mem_rd_en), 0);
        chk({tag, "_mem_rd_addr"},  64'(mem_rd_addr), 0);
        chk({tag, "_refill_valid"}, 64'(refill_valid), 0);
        chk({tag, "_refill_last"},  64'(refill_last), 0);
        chk({tag, "_refill_id"},    64'(refill_id), 0);
        chk({tag, "_refill_beat"},  64'(refill_beat), 0);
        chk({tag, "_refill_data"},  64'(refill_data), 0);
        chk({tag, "_refill_done"},  64'(refill_done), 0);
        chk({tag, "_busy"},         64'(busy), 0);
        chk({tag, "_err_dup_id"},   64'(err_dup_id), 0);
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (refill_done) break;
            step();
        end
        chk("done_seen", 64'(refill_done), 1);
    endtask

    task automatic wait_drained(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk(tag, 64'(sb.size()), 0);
    endtask

    // Beat monitor: scoreboard compare on handshake, stall stability, done decode.
    always @(negedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (refill_valid || refill_done) begin
                chk("done_decode", 64'(refill_done), 64'(refill_valid & refill_ready & refill_last));
                chk("done_id", 64'(refill_done_id), 64'(refill_id));
                chk("no_read_in_send", 64'(mem_rd_en), 0);
            end
            if (stall_q) begin
                chk("stall_valid", 64'(refill_valid), 1);
                chk("stall_fields", 64'({refill_id, refill_beat, refill_data}), 64'(prev_fields));
            end
            if (refill_valid && refill_ready) begin
                chk("beat_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_id",   64'(refill_id),   64'(e.id));
                    chk("beat_idx",  64'(refill_beat), 64'(e.beat));
                    chk("beat_data", 64'(refill_data), 64'(e.data));
                    chk("beat_last", 64'(refill_last), 64'(e.last));
                end
            end
            stall_q     <= refill_valid && !refill_ready;
            prev_fields <= {refill_id, refill_beat, refill_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_line_addr = '0;
        req_id        = '0;
        refill_ready  = 1'b1;
        step();
        step();
        check_reset_vals("por");
        rst = 1'b0;
        step();

        // Single line at full rate: latency and completion timing.
        push_req(LINE_ADDR_W'(26'h1234), ID_W'(2));
        for (int i = 0; i < 100; i++) begin
            if (refill_valid) break;
            step();
        end
        chk("first_valid_seen", 64'(refill_valid), 1);
        chk("first_beat_cycle", 64'(edges + 1 - acc_edge), 12);
        chk("busy_in_line", 64'(busy), 1);
        wait_done(100);
        chk("done_cycle", 64'(edges + 1 - acc_edge), 57);
        chk("done_id_2", 64'(refill_done_id), 2);
        step();
        chk("line_1234_drained", 64'(sb.size()), 0);
        chk("idle_after_line", 64'(busy), 0);

        // Backpressure on beat 3.
        push_req(LINE_ADDR_W'(26'h0ABC), ID_W'(2));
        for (int i = 0; i < 100; i++) begin
            if (mem_rd_en && (mem_rd_addr == ADDR_W'({LINE_ADDR_W'(26'h0ABC), BEAT_W'(3), 2'b00}))) break;
            step();
        end
        chk("bp_read3_seen", 64'(mem_rd_en), 1);
        refill_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (refill_valid) break;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(refill_valid), 1);
            chk("bp_beat", 64'(refill_beat), 3);
            chk("bp_no_read", 64'(mem_rd_en), 0);
            step();
        end
        refill_ready = 1'b1;
        step();
        chk("bp_read4_next", 64'(mem_rd_en), 1);
        chk("bp_read4_addr", 64'(mem_rd_addr), 64'(ADDR_W'({LINE_ADDR_W'(26'h0ABC), BEAT_W'(4), 2'b00})));
        wait_drained("bp_drained", 200);

        // Re-issue id 1 on its completion cycle (legal), then again while pending (error).
        push_req(LINE_ADDR_W'(26'h0100), ID_W'(1));
        for (int i = 0; i < 100; i++) begin
            if (refill_done && (refill_done_id == ID_W'(1))) break;
            step();
        end
        chk("reissue_done_seen", 64'(refill_done), 1);
        chk("reissue_ready", 64'(req_ready), 1);
        req_valid     = 1'b1;
        req_line_addr = LINE_ADDR_W'(26'h0200);
        req_id        = ID_W'(1);
        sb_push_line(LINE_ADDR_W'(26'h0200), ID_W'(1));
        step();
        chk("no_dup_on_reissue", 64'(err_dup_id), 0);
        chk("dup_ready", 64'(req_ready), 1);
        req_line_addr = LINE_ADDR_W'(26'h0300);
        sb_push_line(LINE_ADDR_W'(26'h0300), ID_W'(1));
        step();
        req_valid = 1'b0;
        chk("dup_flag", 64'(err_dup_id), 1);
        wait_drained("dup_drained", 300);
        chk("dup_sticky", 64'(err_dup_id), 1);

        // Queue full behind a stalled line; fifth request waits for the first pop.
        refill_ready = 1'b0;
        push_req(LINE_ADDR_W'(26'h0F00), ID_W'(3));
        for (int i = 0; i < 100; i++) begin
            if (refill_valid) break;
            step();
        end
        chk("blocker_stalled", 64'(refill_valid), 1);
        for (int k = 0; k < 4; k++) push_req(LINE_ADDR_W'(26'h0010 + k), ID_W'(k));
        chk("full_ready_low", 64'(req_ready), 0);
        req_valid     = 1'b1;
        req_line_addr = LINE_ADDR_W'(26'h0014);
        req_id        = ID_W'(0);
        refill_ready  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) break;
            step();
        end
        chk("fifth_admitted", 64'(req_ready), 1);
        chk("fifth_after_pop", 64'(sb.size()), 64);
        sb_push_line(LINE_ADDR_W'(26'h0014), ID_W'(0));
        step();
        req_valid = 1'b0;
        wait_drained("full_drained", 500);

        // Reset while waiting on memory latency.
        push_req(LINE_ADDR_W'(26'h0020), ID_W'(1));
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_vals("rst_wait");
        sb.delete();
        rst = 1'b0;
        step();

        // Reset while sending beat 7.
        push_req(LINE_ADDR_W'(26'h0021), ID_W'(2));
        for (int i = 0; i < 100; i++) begin
            if (refill_valid && (refill_beat == BEAT_W'(7))) break;
            step();
        end
        chk("beat7_seen", 64'(refill_beat), 7);
        rst = 1'b1;
        step();
        check_reset_vals("rst_send");
        sb.delete();
        rst = 1'b0;
        step();
        chk("post_reset_quiet", 64'(refill_valid), 0);

        // Fresh request after reset completes normally.
        push_req(LINE_ADDR_W'(26'h0022), ID_W'(2));
        wait_done(100);
        chk("fresh_done_cycle", 64'(edges + 1 - acc_edge), 57);
        chk("fresh_done_id", 64'(refill_done_id), 2);
        step();
        chk("fresh_drained", 64'(sb.size()), 0);
        chk("fresh_no_err", 64'(err_dup_id), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_refill_responder.md
# l1_refill_responder

Memory-side responder for L1 data-cache line-fill requests, sitting between the dcache MSHR array and the backing store. It queues line requests tagged with an MSHR id and waits a fixed memory latency. It then reads the line word by word from a synchronous backing-memory port and returns it as tagged refill beats. On the last accepted beat it pulses the per-id completion that frees the MSHR entry.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, beat/word width (multiple of 8)
- LINE_BYTES, 64, line size; BEATS = LINE_BYTES/(DATA_W/8) = 16
- NUM_MSHR, 4, id space and request-queue depth; ID_W = $clog2(NUM_MSHR)
- MEM_LATENCY, 8, cycles spent in WAIT per line (must be ≥1)
- Derived: OFFSET_W = $clog2(LINE_BYTES), LINE_ADDR_W = ADDR_W-OFFSET_W, BEAT_W = $clog2(BEATS), WB = $clog2(DATA_W/8)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  line-fill request
- req_ready  out  1  queue not full
- req_line_addr  in  LINE_ADDR_W  line address
- req_id  in  ID_W  requesting MSHR id
- mem_rd_en  out  1  backing-memory read strobe
- mem_rd_addr  out  ADDR_W  word-aligned byte address
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
- refill_valid  out  1  refill beat available
- refill_ready  in  1  consumer accepts beat
- refill_id / refill_beat / refill_data / refill_last  out  ID_W / BEAT_W / DATA_W / 1  beat tag, index, payload, final-beat flag
- refill_done  out  1  = refill_valid & refill_ready & refill_last (feeds MSHR completion)
- refill_done_id  out  ID_W  = refill_id
- busy  out  1  state≠IDLE or queue non-empty
- err_dup_id  out  1  sticky; request accepted for an id already pending

## Operation
- Request queue: FIFO of {line_addr, id}, depth NUM_MSHR. Push on req_valid & req_ready. req_ready = !full, independent of pop in the same cycle.
- Pending mask [NUM_MSHR]: bit set on accept, cleared on refill_done. If both hit the same id in one cycle, set wins.
- err_dup_id sets when an id is accepted whose pending bit is 1 and not cleared that cycle. The request is still queued and served. Cleared only by rst.
- FSM states:
  - IDLE: if queue non-empty, pop into cur_line/cur_id, beat←0, lat_cnt←MEM_LATENCY-1, go to WAIT.
  - WAIT: decrement lat_cnt; at 0 go to READ.
  - READ: mem_rd_en=1 for one cycle, mem_rd_addr = {cur_line, beat, WB'0}; go to RESP.
  - RESP: data_q←mem_rd_data; go to SEND.
  - SEND: refill_valid=1. Beat fields are driven from registers and are stable while stalled. On handshake, if beat==BEATS-1 go to IDLE, else beat++ and go to READ.
- Lines are served strictly in acceptance order, one at a time. There is no interleaving between ids.
- beat counts 0..BEATS-1 with no wrap inside a line.

## Timing
- Reset values: req_ready=1, mem_rd_en=0, mem_rd_addr=0, refill_valid=0, refill_last=0, refill_id/beat/data=0, refill_done=0, busy=0, err_dup_id=0. FSM=IDLE, queue empty, pending=0.
- Accept at edge t, with the queue empty and the FSM idle:
  - Pop in cycle t+1.
  - WAIT spans t+2..t+1+MEM_LATENCY.
  - READ beat 0 at t+2+L.
  - First refill_valid at t+4+L (t+12 for L=8).
- With refill_ready held high, each beat takes 3 cycles. The last beat is handshaken at t+4+L+3·(BEATS-1) (t+57 at defaults).
- After the last beat the FSM spends one cycle in IDLE before the next line's pop. The next line's first beat appears L+4 cycles after the last handshake.
- refill_valid must not drop and beat fields must not change until the handshake completes.
- Reset asserted mid-line: all state is discarded immediately. No refill_done is issued for in-flight or queued ids.

## Structure
- Package l1_refill_pkg:
  - derived localparam functions (BEATS, BEAT_W, OFFSET_W, LINE_ADDR_W);
  - packed struct refill_req_t {line_addr, id};
  - FSM enum {IDLE, WAIT, READ, RESP, SEND}.
- Sub-module l1_refill_req_fifo: parameterized-depth FIFO of refill_req_t with full/empty and a count.
- The top level holds the FSM, the latency and beat counters, the pending mask, and data_q.

## Test plan
- Single request, line 0x1234, id 2, L=8, ready high, memory word = address → 16 beats with data 0x48D00+4·k, first beat at t+12, refill_done with id 2 at t+57.
- Backpressure: refill_ready low for 5 cycles during beat 3 → refill_valid/beat/data held constant, no extra mem_rd_en, beat 4 READ starts the cycle after the handshake.
- Queue full: 4 requests (ids 0-3) back-to-back → req_ready=0 after the 4th; a 5th is held off until the first pop; lines return in order 0,1,2,3.
- Duplicate id: id 1 accepted twice while the first is pending → err_dup_id=1 and sticky; both lines served. Re-issue of id 1 in the same cycle as its refill_done → no error.
- Reset during WAIT and during SEND beat 7 → all outputs at reset values next cycle, req_ready=1, no refill_done; a fresh request then completes normally.
